// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and bus acknowledge levels.
// Used by the target below and by the SoC-side I2C master.
package i2c_pkg;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StAddr     = 3'd1,
        StAddrAck  = 3'd2,
        StWrData   = 3'd3,
        StWrAck    = 3'd4,
        StRdData   = 3'd5,
        StRdAck    = 3'd6,
        StWaitStop = 3'd7
    } i2c_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser plus one history flop; flags SCL edges and START/STOP.
// Flops reset high so a released (idle) bus produces no false edges.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STG = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start_det,
    output logic o_stop_det,
    output logic o_sda_s
);

    logic [SYNC_STG-1:0] r_scl_sync;
    logic [SYNC_STG-1:0] r_sda_sync;
    logic                r_scl_hist;
    logic                r_sda_hist;
    logic                w_scl;
    logic                w_sda;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STG-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STG-2:0], i_sda};
            r_scl_hist <= r_scl_sync[SYNC_STG-1];
            r_sda_hist <= r_sda_sync[SYNC_STG-1];
        end
    end

    assign w_scl = r_scl_sync[SYNC_STG-1];
    assign w_sda = r_sda_sync[SYNC_STG-1];

    assign o_scl_rise  = w_scl & ~r_scl_hist;
    assign o_scl_fall  = ~w_scl & r_scl_hist;
    // SDA may only move under a steady-high SCL for a START/STOP.
    assign o_start_det = w_scl & r_scl_hist & r_sda_hist & ~w_sda;
    assign o_stop_det  = w_scl & r_scl_hist & ~r_sda_hist & w_sda;
    assign o_sda_s     = w_sda;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target with a DEPTH x 8 register file; bus writes/reads auto-increment a byte pointer.
// A host port preloads and inspects the file; a bus write wins an index collision.
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLV_ADDR = 7'h42,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned SYNC_STG = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_oe_o,
    input  logic                     h_we_i,
    input  logic [$clog2(DEPTH)-1:0] h_addr_i,
    input  logic [7:0]               h_wdata_i,
    output logic [7:0]               h_rdata_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [7:0]               wr_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic          w_scl_rise;
    logic          w_scl_fall;
    logic          w_start;
    logic          w_stop;
    logic          w_sda_s;
    logic [7:0]    w_shift_nxt;
    logic          w_bus_we;

    i2c_state_e    r_state;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    logic          r_flag;
    logic          r_rw;
    logic [AW-1:0] r_ptr;
    logic          r_match;
    logic          r_sda_oe;
    logic          r_busy;
    logic          r_done;
    logic [7:0]    r_wr_cnt;
    logic [7:0]    r_mem [DEPTH];

    i2c_bus_sync #(
        .SYNC_STG(SYNC_STG)
    ) u_sync (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_scl       (scl_i),
        .i_sda       (sda_i),
        .o_scl_rise  (w_scl_rise),
        .o_scl_fall  (w_scl_fall),
        .o_start_det (w_start),
        .o_stop_det  (w_stop),
        .o_sda_s     (w_sda_s)
    );

    assign w_shift_nxt = {r_shift[6:0], w_sda_s};
    assign w_bus_we    = rst_i && (r_state == StWrData) && w_scl_fall && r_flag;

    // r_flag: a full byte has been shifted in (ADDR/WR_DATA), bit 0 is on the bus
    // (RD_DATA), or the controller has ACKed (RD_ACK).
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state   <= StIdle;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_flag    <= 1'b0;
            r_rw      <= 1'b0;
            r_ptr     <= '0;
            r_match   <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wr_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_start) begin
                r_state   <= StAddr;
                r_bit_cnt <= 3'd7;
                r_flag    <= 1'b0;
                r_ptr     <= '0;
                r_match   <= 1'b0;
                r_busy    <= 1'b1;
                r_sda_oe  <= 1'b0;
            end else if (w_stop) begin
                r_state  <= StIdle;
                r_busy   <= 1'b0;
                r_sda_oe <= 1'b0;
                r_done   <= r_match;
            end else begin
                case (r_state)
                    StAddr, StWrData: begin
                        if (w_scl_rise) begin
                            r_shift <= w_shift_nxt;
                            if (r_bit_cnt == 3'd0) begin
                                r_flag <= 1'b1;
                                if (r_state == StAddr) begin
                                    r_rw    <= w_sda_s;
                                    r_match <= (r_shift[6:0] == SLV_ADDR);
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt - 3'd1;
                            end
                        end else if (w_scl_fall && r_flag) begin
                            r_flag <= 1'b0;
                            if (r_state == StWrData) begin
                                r_ptr    <= r_ptr + AW'(1);
                                r_wr_cnt <= sat_inc8(r_wr_cnt);
                                r_state  <= StWrAck;
                                r_sda_oe <= 1'b1;
                            end else if (r_match) begin
                                r_state  <= StAddrAck;
                                r_sda_oe <= 1'b1;
                                r_wr_cnt <= '0;
                            end else begin
                                r_state <= StWaitStop;
                            end
                        end
                    end
                    StAddrAck: begin
                        if (w_scl_fall) begin
                            r_flag <= 1'b0;
                            if (r_rw) begin
                                r_state   <= StRdData;
                                r_sda_oe  <= ~r_mem[r_ptr][7];
                                r_bit_cnt <= 3'd6;
                            end else begin
                                r_state   <= StWrData;
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 3'd7;
                            end
                        end
                    end
                    StWrAck: begin
                        if (w_scl_fall) begin
                            r_state   <= StWrData;
                            r_sda_oe  <= 1'b0;
                            r_bit_cnt <= 3'd7;
                        end
                    end
                    StRdData: begin
                        if (w_scl_fall) begin
                            if (r_flag) begin
                                r_flag   <= 1'b0;
                                r_sda_oe <= 1'b0;
                                r_ptr    <= r_ptr + AW'(1);
                                r_state  <= StRdAck;
                            end else begin
                                r_sda_oe <= ~r_mem[r_ptr][r_bit_cnt];
                                if (r_bit_cnt == 3'd0) begin
                                    r_flag <= 1'b1;
                                end else begin
                                    r_bit_cnt <= r_bit_cnt - 3'd1;
                                end
                            end
                        end
                    end
                    StRdAck: begin
                        if (w_scl_rise) begin
                            if (w_sda_s == NACK) begin
                                r_state <= StWaitStop;
                            end else begin
                                r_flag <= 1'b1;
                            end
                        end else if (w_scl_fall && r_flag) begin
                            r_flag    <= 1'b0;
                            r_state   <= StRdData;
                            r_sda_oe  <= ~r_mem[r_ptr][7];
                            r_bit_cnt <= 3'd6;
                        end
                    end
                    StIdle, StWaitStop: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    // Bus write is the later assignment, so it wins a same-index collision.
    always_ff @(posedge clk_i) begin
        if (h_we_i) begin
            r_mem[h_addr_i] <= h_wdata_i;
        end
        if (w_bus_we) begin
            r_mem[r_ptr] <= r_shift;
        end
    end

    assign h_rdata_o = r_mem[h_addr_i];
    assign sda_oe_o  = r_sda_oe;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign wr_cnt_o  = r_wr_cnt;

endmodule
